syn_sync_ff: RTL and testbench
==============================

SYN_SYNC_FF -- requirements
Module: syn_sync_ff

Interface
REQ-001 Parameter DATA_W, default 8, width of each FIFO word.
REQ-002 Parameter DEPTH, default 16, number of words, power of 2, minimum 2.
REQ-003 clk_ir  input  1  single clock; all state updates on rising edge.
REQ-004 rst_il  input  1  asynchronous active-low reset.
REQ-005 ff_wr_en  input  1  write request, FIFO slave side.
REQ-006 ff_wr_data  input  DATA_W  write word.
REQ-007 ff_rd_en  input  1  read request.
REQ-008 ff_rd_data  output  DATA_W  read word, registered.
REQ-009 ff_full  output  1  no free location.
REQ-010 ff_empty  output  1  no stored word.
REQ-011 ff_occ  output  $clog2(DEPTH)+1  current word count.
REQ-012 ff_ovfl / ff_udfl  output  1 each  sticky error flags; present only with SYN_FF_ERR_DET_EN.
REQ-013 The ff_* ports SHALL be exposed as the ff_slave modport of an ff_intf instance, with DATA_TYPE = logic [DATA_W-1:0].

Function
REQ-014 A write SHALL be accepted on a clock edge where ff_wr_en=1 and ff_full=0; the word is stored at wr_ptr and wr_ptr increments.
REQ-015 A read SHALL be accepted on a clock edge where ff_rd_en=1 and ff_empty=0; the word at rd_ptr is loaded into ff_rd_data on that edge and rd_ptr increments (1-cycle latency).
REQ-016 ff_rd_data SHALL hold its last value when no read is accepted.
REQ-017 Writes while full SHALL be dropped with no state change, even if a read is accepted on the same edge.
REQ-018 Reads while empty SHALL be ignored with no state change, even if a write is accepted on the same edge.
REQ-019 A simultaneous accepted write and read SHALL leave ff_occ unchanged.
REQ-020 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 modulo 2^n.
REQ-021 ff_occ SHALL be a registered counter: +1 on write-only, -1 on read-only, otherwise hold; range 0..DEPTH.
REQ-022 ff_full SHALL equal (ff_occ==DEPTH) and ff_empty SHALL equal (ff_occ==0), both registered, valid the edge after the causing access.
REQ-023 No read-during-write bypass: a word written on edge N SHALL be readable no earlier than edge N+1.

Reset
REQ-024 Asserting rst_il SHALL immediately clear wr_ptr, rd_ptr and ff_occ, set ff_empty=1, ff_full=0, ff_rd_data=0, and ff_ovfl=ff_udfl=0 when present.
REQ-025 Memory contents SHALL NOT be reset; reset mid-operation discards all stored words.
REQ-026 Deassertion SHALL take effect at the next rising edge; accesses on that edge are honoured.

Configuration
REQ-027 Macro SYN_FF_ERR_DET_EN defined: ff_ovfl SHALL set on any edge with ff_wr_en=1 and ff_full=1, ff_udfl on any edge with ff_rd_en=1 and ff_empty=1; both clear only on reset.
REQ-028 Macro undefined: ff_ovfl/ff_udfl ports and their logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package syn_ff_pkg SHALL hold the pointer-width function and occupancy/pointer typedefs derived from DEPTH.
REQ-030 Storage SHALL be a sub-module syn_ff_mem: simple dual-port, synchronous write, synchronous registered read, no reset, inferable as block RAM.
REQ-031 Pointer, occupancy and flag logic SHALL reside in syn_sync_ff.

Verification (DEPTH=4, DATA_W=8)
REQ-032 Write 0x11,0x22,0x33,0x44 back-to-back -> ff_full=1 and ff_occ=4 after 4th edge; read 4 -> data 0x11..0x44 in order, each 1 cycle after its rd_en, ff_empty=1.
REQ-033 When full, assert wr_en with 0x55 and rd_en together -> read returns 0x11, 0x55 dropped, ff_occ=3; with macro, ff_ovfl=1.
REQ-034 When empty, assert wr_en with 0xA5 and rd_en together -> read ignored, ff_occ=1, ff_rd_data unchanged; next read returns 0xA5; with macro, ff_udfl=1.
REQ-035 Stream 10 words with simultaneous wr/rd at occ=2 -> pointers wrap, ff_occ stays 2, output order matches input order.
REQ-036 Assert rst_il low mid-stream at occ=3 -> ff_empty=1, ff_occ=0, ff_rd_data=0, error flags 0 before next edge; subsequent write/read of 0x7E returns 0x7E.

Source files
------------

// File: rtl/syn_ff_pkg.sv
// Shared sizing helpers and typedefs for the synchronous FIFO.
// The default typedefs track FF_DEPTH_DFLT. Parameterised users derive their own widths with ff_ptr_w().
package syn_ff_pkg;

  localparam int FF_DEPTH_DFLT = 16;

  // Pointer width for a power-of-2 depth; a depth of 1 still gets one bit.
  function automatic int ff_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef logic [ff_ptr_w(FF_DEPTH_DFLT)-1:0] ff_ptr_t;
  typedef logic [ff_ptr_w(FF_DEPTH_DFLT):0]   ff_occ_t;

  // Accesses actually accepted on this edge, after the full/empty gating.
  typedef struct packed {
    logic wr;
    logic rd;
  } ff_acc_t;

endpackage

// File: rtl/syn_sync_ff_if.sv
// FIFO handshake bundle (ff_intf). The ff_ovfl/ff_udfl sticky error flags exist only
// when SYN_FF_ERR_DET_EN is defined.
interface ff_intf
  import syn_ff_pkg::*;
#(
  parameter type DATA_TYPE = logic [7:0],
  parameter int  DEPTH     = 16
);
  localparam int OCC_W = ff_ptr_w(DEPTH) + 1;

  logic             ff_wr_en;
  DATA_TYPE         ff_wr_data;
  logic             ff_rd_en;
  DATA_TYPE         ff_rd_data;
  logic             ff_full;
  logic             ff_empty;
  logic [OCC_W-1:0] ff_occ;

`ifdef SYN_FF_ERR_DET_EN
  logic ff_ovfl;
  logic ff_udfl;

  modport ff_slave (
    input  ff_wr_en, ff_wr_data, ff_rd_en,
    output ff_rd_data, ff_full, ff_empty, ff_occ, ff_ovfl, ff_udfl
  );
  modport ff_master (
    output ff_wr_en, ff_wr_data, ff_rd_en,
    input  ff_rd_data, ff_full, ff_empty, ff_occ, ff_ovfl, ff_udfl
  );
`else
  modport ff_slave (
    input  ff_wr_en, ff_wr_data, ff_rd_en,
    output ff_rd_data, ff_full, ff_empty, ff_occ
  );
  modport ff_master (
    output ff_wr_en, ff_wr_data, ff_rd_en,
    input  ff_rd_data, ff_full, ff_empty, ff_occ
  );
`endif

endinterface

// File: rtl/syn_ff_mem.sv
// Simple dual-port FIFO storage: synchronous write, registered read, no reset.
// It is coded so that synthesis maps it onto block RAM.
module syn_ff_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk_ir,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // The read register only loads on an accepted read, so it holds the last word otherwise.
  always_ff @(posedge clk_ir) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q      <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/syn_sync_ff.sv
// Single-clock FIFO: pointer, occupancy and flag logic around a syn_ff_mem storage array.
// Defining SYN_FF_ERR_DET_EN adds the sticky ff_ovfl/ff_udfl error flags.
module syn_sync_ff
  import syn_ff_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic  clk_ir,
  input  logic  rst_il,
  ff_intf.ff_slave ff
);

  localparam int PW = ff_ptr_w(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   occ_t;

  ff_acc_t           acc;
  ptr_t              wr_ptr_q, wr_ptr_d;
  ptr_t              rd_ptr_q, rd_ptr_d;
  occ_t              occ_q, occ_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0] mem_rd_data;

  always_comb begin
    acc.wr   = ff.ff_wr_en & ~full_q;
    acc.rd   = ff.ff_rd_en & ~empty_q;
    wr_ptr_d = wr_ptr_q + ptr_t'(acc.wr);
    rd_ptr_d = rd_ptr_q + ptr_t'(acc.rd);
    occ_d    = occ_q;
    case ({acc.wr, acc.rd})
      2'b10:   occ_d = occ_q + occ_t'(1);
      2'b01:   occ_d = occ_q - occ_t'(1);
      default: occ_d = occ_q;
    endcase
    full_d   = (occ_d == occ_t'(DEPTH));
    empty_d  = (occ_d == '0);
    rd_vld_d = rd_vld_q | acc.rd;
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      rd_vld_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  // Writes and reads never address the same word on one edge: an accepted read needs a stored
  // word, and an accepted write needs a free slot. Neither case lets the two pointers meet.
  syn_ff_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PW)
  ) u_mem (
    .clk_ir  (clk_ir),
    .wr_en   (acc.wr),
    .wr_addr (wr_ptr_q),
    .wr_data (ff.ff_wr_data),
    .rd_en   (acc.rd),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rd_data)
  );

  // The RAM output register cannot be reset, so a reset-cleared qualifier forces zero until the first read.
  assign ff.ff_rd_data = rd_vld_q ? mem_rd_data : '0;
  assign ff.ff_full    = full_q;
  assign ff.ff_empty   = empty_q;
  assign ff.ff_occ     = occ_q;

`ifdef SYN_FF_ERR_DET_EN
  logic ovfl_q, ovfl_d;
  logic udfl_q, udfl_d;

  always_comb begin
    ovfl_d = ovfl_q | (ff.ff_wr_en & full_q);
    udfl_d = udfl_q | (ff.ff_rd_en & empty_q);
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      ovfl_q <= 1'b0;
      udfl_q <= 1'b0;
    end else begin
      ovfl_q <= ovfl_d;
      udfl_q <= udfl_d;
    end
  end

  assign ff.ff_ovfl = ovfl_q;
  assign ff.ff_udfl = udfl_q;
`endif

endmodule

// File: tb/tb_syn_sync_ff.sv
// Bench for syn_sync_ff (DEPTH=4, DATA_W=8) against a queue-based FIFO model.
// The error-flag checks are compiled in when SYN_FF_ERR_DET_EN is defined.
module tb_syn_sync_ff;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic clk_ir = 1'b0;
  logic rst_il;
  always #5 clk_ir = ~clk_ir;

  ff_intf #(.DATA_TYPE(logic [DW-1:0]), .DEPTH(DEPTH)) ff ();

  syn_sync_ff #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk_ir (clk_ir),
    .rst_il (rst_il),
    .ff     (ff.ff_slave)
  );

  int errs   = 0;
  int checks = 0;

  logic [DW-1:0] m_q [$];
  logic [DW-1:0] m_rd;
`ifdef SYN_FF_ERR_DET_EN
  bit m_ovfl, m_udfl;
`endif

  // Apply one access, advance one edge and update the model, then sample 1 unit after the edge.
  task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd);
    bit aw, ar;
    @(negedge clk_ir);
    ff.ff_wr_en = wr; ff.ff_wr_data = d; ff.ff_rd_en = rd;
    @(posedge clk_ir);
    aw = wr && (m_q.size() < DEPTH);
    ar = rd && (m_q.size() != 0);
`ifdef SYN_FF_ERR_DET_EN
    if (wr && m_q.size() == DEPTH) m_ovfl = 1;
    if (rd && m_q.size() == 0)     m_udfl = 1;
`endif
    if (ar) m_rd = m_q.pop_front();
    if (aw) m_q.push_back(d);
    #1;
    ff.ff_wr_en = 0; ff.ff_rd_en = 0;
  endtask

  task automatic test_reset();
    rst_il = 0; ff.ff_wr_en = 0; ff.ff_rd_en = 0; ff.ff_wr_data = '0;
    m_q.delete(); m_rd = '0;
    #12;
    checks++;
    if (ff.ff_occ !== '0 || ff.ff_empty !== 1'b1 || ff.ff_full !== 1'b0 || ff.ff_rd_data !== '0) begin
      errs++;
      $display("FAIL reset: occ=%0d empty=%b full=%b rd=%h, want 0 1 0 00",
               ff.ff_occ, ff.ff_empty, ff.ff_full, ff.ff_rd_data);
    end
`ifdef SYN_FF_ERR_DET_EN
    m_ovfl = 0; m_udfl = 0;
    checks++;
    if (ff.ff_ovfl !== 1'b0 || ff.ff_udfl !== 1'b0) begin
      errs++; $display("FAIL reset_flags: ovfl=%b udfl=%b, want 0 0", ff.ff_ovfl, ff.ff_udfl);
    end
`endif
    @(negedge clk_ir); rst_il = 1;
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] exp;
    for (int i = 0; i < DEPTH; i++) begin
      step(1, DW'(8'h11 * (i + 1)), 0);
      checks++;
      if (ff.ff_occ !== OCC_W'(i + 1)) begin
        errs++; $display("FAIL fill_occ[%0d]: got %0d want %0d", i, ff.ff_occ, i + 1);
      end
    end
    checks++;
    if (ff.ff_full !== 1'b1 || ff.ff_occ !== OCC_W'(4)) begin
      errs++; $display("FAIL fill_full: full=%b occ=%0d, want 1 4", ff.ff_full, ff.ff_occ);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, '0, 1);
      exp = DW'(8'h11 * (i + 1));
      checks++;
      if (ff.ff_rd_data !== exp || m_rd !== exp) begin
        errs++; $display("FAIL drain_data[%0d]: got %h want %h", i, ff.ff_rd_data, exp);
      end
    end
    checks++;
    if (ff.ff_empty !== 1'b1 || ff.ff_occ !== '0) begin
      errs++; $display("FAIL drain_empty: empty=%b occ=%0d, want 1 0", ff.ff_empty, ff.ff_occ);
    end
  endtask

  task automatic test_full_wr_rd();
    for (int i = 0; i < DEPTH; i++) step(1, DW'(8'h11 * (i + 1)), 0);
    step(1, 8'h55, 1);
    checks++;
    if (ff.ff_rd_data !== 8'h11 || ff.ff_occ !== OCC_W'(3)) begin
      errs++; $display("FAIL full_wr_rd: rd=%h occ=%0d, want 11 3", ff.ff_rd_data, ff.ff_occ);
    end
`ifdef SYN_FF_ERR_DET_EN
    checks++;
    if (ff.ff_ovfl !== 1'b1) begin
      errs++; $display("FAIL ovfl: got %b want 1", ff.ff_ovfl);
    end
`endif
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 1);
      checks++;
      if (ff.ff_rd_data !== DW'(8'h22 + 8'h11 * i)) begin
        errs++; $display("FAIL full_drop[%0d]: got %h want %h", i, ff.ff_rd_data, 8'h22 + 8'h11 * i);
      end
    end
  endtask

  task automatic test_empty_wr_rd();
    logic [DW-1:0] prev;
    prev = m_rd;
    step(1, 8'hA5, 1);
    checks++;
    if (ff.ff_rd_data !== prev || ff.ff_occ !== OCC_W'(1) || ff.ff_empty !== 1'b0) begin
      errs++; $display("FAIL empty_wr_rd: rd=%h occ=%0d empty=%b, want %h 1 0",
                       ff.ff_rd_data, ff.ff_occ, ff.ff_empty, prev);
    end
`ifdef SYN_FF_ERR_DET_EN
    checks++;
    if (ff.ff_udfl !== 1'b1) begin
      errs++; $display("FAIL udfl: got %b want 1", ff.ff_udfl);
    end
`endif
    step(0, '0, 1);
    checks++;
    if (ff.ff_rd_data !== 8'hA5) begin
      errs++; $display("FAIL empty_next_rd: got %h want a5", ff.ff_rd_data);
    end
  endtask

  task automatic test_stream();
    step(1, 8'h01, 0);
    step(1, 8'h02, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, DW'($urandom), 1);
      checks++;
      if (ff.ff_occ !== OCC_W'(2) || ff.ff_rd_data !== m_rd) begin
        errs++; $display("FAIL stream[%0d]: occ=%0d rd=%h, want 2 %h", i, ff.ff_occ, ff.ff_rd_data, m_rd);
      end
      if (i < 2) begin
        checks++;
        if (ff.ff_rd_data !== DW'(i + 1)) begin
          errs++; $display("FAIL stream_head[%0d]: got %h want %0d", i, ff.ff_rd_data, i + 1);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    step(1, 8'h99, 0);
    checks++;
    if (ff.ff_occ !== OCC_W'(3)) begin
      errs++; $display("FAIL pre_reset_occ: got %0d want 3", ff.ff_occ);
    end
    @(negedge clk_ir); #1;
    rst_il = 0;
    #1;
    m_q.delete(); m_rd = '0;
    checks++;
    if (ff.ff_empty !== 1'b1 || ff.ff_occ !== '0 || ff.ff_rd_data !== '0 || ff.ff_full !== 1'b0) begin
      errs++; $display("FAIL mid_reset: empty=%b occ=%0d rd=%h full=%b, want 1 0 00 0",
                       ff.ff_empty, ff.ff_occ, ff.ff_rd_data, ff.ff_full);
    end
`ifdef SYN_FF_ERR_DET_EN
    m_ovfl = 0; m_udfl = 0;
    checks++;
    if (ff.ff_ovfl !== 1'b0 || ff.ff_udfl !== 1'b0) begin
      errs++; $display("FAIL mid_reset_flags: ovfl=%b udfl=%b, want 0 0", ff.ff_ovfl, ff.ff_udfl);
    end
`endif
    #1 rst_il = 1;
    step(1, 8'h7E, 0);
    step(0, '0, 1);
    checks++;
    if (ff.ff_rd_data !== 8'h7E || ff.ff_empty !== 1'b1) begin
      errs++; $display("FAIL post_reset: rd=%h empty=%b, want 7e 1", ff.ff_rd_data, ff.ff_empty);
    end
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 300; i++) begin
      step(bit'($urandom_range(0, 1)), DW'($urandom), bit'($urandom_range(0, 1)));
      n = m_q.size();
      checks++;
      if (ff.ff_occ !== OCC_W'(n) || ff.ff_full !== (n == DEPTH) ||
          ff.ff_empty !== (n == 0) || ff.ff_rd_data !== m_rd) begin
        errs++; $display("FAIL random[%0d]: occ=%0d full=%b empty=%b rd=%h, want occ=%0d rd=%h",
                         i, ff.ff_occ, ff.ff_full, ff.ff_empty, ff.ff_rd_data, n, m_rd);
      end
`ifdef SYN_FF_ERR_DET_EN
      checks++;
      if (ff.ff_ovfl !== m_ovfl || ff.ff_udfl !== m_udfl) begin
        errs++; $display("FAIL random_flags[%0d]: ovfl=%b udfl=%b, want %b %b",
                         i, ff.ff_ovfl, ff.ff_udfl, m_ovfl, m_udfl);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_wr_rd();
    test_empty_wr_rd();
    test_stream();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
